// File: rtl/cs_response_packer.sv
// cs_response_packer
// Collects register-readback / RSSI response records in the clk64 domain and
// packs them into one 128-word in-band packet on control channel 0x1F. The
// packet is streamed word-by-word onto the rx_WR write bus.
//
// Ports:
//   clk64          clk64 domain clock
//   reset          synchronous, active-high reset
//   resp_valid     response record offered
//   resp_ready     record taken on a cycle with resp_valid & resp_ready
//   resp_opcode    subpacket opcode (8 bits)
//   resp_rid       request id echoed to the host (6 bits)
//   resp_data      response value (32 bits)
//   rx_WR_enabled  consumer has room for one full packet
//   rx_WR          rx_databus holds a valid packet word
//   rx_databus     packet word (16 bits)
//   rx_WR_done     one-cycle pulse after the last word of a packet
//   pkts_sent      count of completed packets, wraps
module cs_response_packer #(
    parameter int PKT_WORDS     = 128,
    parameter int MAX_SUB       = 31,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic        clk64,
    input  logic        reset,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [7:0]  resp_opcode,
    input  logic [5:0]  resp_rid,
    input  logic [31:0] resp_data,
    input  logic        rx_WR_enabled,
    output logic        rx_WR,
    output logic [15:0] rx_databus,
    output logic        rx_WR_done,
    output logic [15:0] pkts_sent
);

    localparam int                 TIMER_W    = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT    = TIMER_W'(FLUSH_TIMEOUT);
    localparam logic [6:0]         LAST_IDX   = 7'(PKT_WORDS - 1);
    localparam logic [5:0]         FULL_COUNT = 6'(MAX_SUB);
    localparam logic [4:0]         LAST_SLOT  = 5'(MAX_SUB - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [6:0]         widx;
    logic [6:0]         widx_next;
    logic [6:0]         next_idx;
    logic [4:0]         sub_idx;
    logic [5:0]         count;
    logic [5:0]         sub_count;
    logic [4:0]         wr_ptr;
    logic [4:0]         rd_ptr;
    logic [TIMER_W-1:0] timer;
    logic [45:0]        fifo_mem [MAX_SUB];
    logic [45:0]        head;
    logic [7:0]         head_opcode;
    logic [5:0]         head_rid;
    logic [31:0]        head_data;
    logic               push;
    logic               pop;
    logic               start_flush;
    logic               latch_len;
    logic               wr_next;
    logic               done_next;
    logic [15:0]        word_next;
    logic [15:0]        pkts_sent_next;

    // Flush when the FIFO is full or the oldest record has aged out, but only
    // while the consumer reports room for a whole packet.
    assign start_flush = (state == COLLECT) && rx_WR_enabled &&
                         ((count == FULL_COUNT) || ((count != 6'd0) && (timer >= TIMEOUT)));

    // A record is never taken on the flush cycle, so the latched length always
    // matches what gets popped during EMIT.
    assign resp_ready = !reset && (state == COLLECT) && (count < FULL_COUNT) && !start_flush;
    assign push       = resp_valid && resp_ready;

    assign head        = fifo_mem[rd_ptr];
    assign head_opcode = head[45:38];
    assign head_rid    = head[37:32];
    assign head_data   = head[31:0];

    // Word widx is on the bus; the word being prepared is widx+1. Subpacket k
    // occupies words 4+4k..7+4k, hence the slot is next_idx/4 - 1.
    assign next_idx = widx + 7'd1;
    assign sub_idx  = next_idx[6:2] - 5'd1;

    assign pkts_sent_next = pkts_sent + {15'd0, (state == DONE)};

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_next = state;
        widx_next  = widx;
        wr_next    = 1'b0;
        word_next  = 16'h0000;
        done_next  = 1'b0;
        pop        = 1'b0;
        latch_len  = 1'b0;
        unique case (state)
            COLLECT: begin
                if (start_flush) begin
                    state_next = EMIT;
                    widx_next  = 7'd0;
                    wr_next    = 1'b1;
                    word_next  = {3'b000, 4'h0, count, 3'b000};
                    latch_len  = 1'b1;
                end
            end
            EMIT: begin
                if (widx == LAST_IDX) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    widx_next = next_idx;
                    wr_next   = 1'b1;
                    if (next_idx == 7'd1) begin
                        word_next = 16'h001F;
                    end else if (next_idx < 7'd4) begin
                        word_next = 16'hFFFF;
                    end else if ({1'b0, sub_idx} < sub_count) begin
                        unique case (next_idx[1:0])
                            2'd0: word_next = {head_opcode, 8'd6};
                            2'd1: word_next = {10'b0, head_rid};
                            2'd2: word_next = head_data[31:16];
                            default: begin
                                word_next = head_data[15:0];
                                pop       = 1'b1;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // State register, FIFO bookkeeping, flush timer and registered bus outputs.
    always_ff @(posedge clk64) begin
        if (reset) begin
            state      <= COLLECT;
            widx       <= 7'd0;
            sub_count  <= 6'd0;
            count      <= 6'd0;
            wr_ptr     <= 5'd0;
            rd_ptr     <= 5'd0;
            timer      <= '0;
            rx_WR      <= 1'b0;
            rx_databus <= 16'h0000;
            rx_WR_done <= 1'b0;
            pkts_sent  <= 16'h0000;
        end else begin
            state      <= state_next;
            widx       <= widx_next;
            rx_WR      <= wr_next;
            rx_databus <= word_next;
            rx_WR_done <= done_next;
            pkts_sent  <= pkts_sent_next;
            if (latch_len) begin
                sub_count <= count;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? 5'd0 : wr_ptr + 5'd1;
                count  <= count + 6'd1;
            end else if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? 5'd0 : rd_ptr + 5'd1;
                count  <= count - 6'd1;
            end
            // The timer stays at zero until the first record is in the FIFO,
            // then ages that record; it holds during EMIT and clears in DONE.
            if ((count == 6'd0) || (state == DONE)) begin
                timer <= '0;
            end else if ((state == COLLECT) && (timer != TIMEOUT)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Record storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk64) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {resp_opcode, resp_rid, resp_data};
        end
    end

endmodule

// File: tb/tb_cs_response_packer.sv
// tb_cs_response_packer
// Directed testbench for cs_response_packer: timeout flush, full packet,
// backpressure, enable drop and reset during emission, and counter wrap.
module tb_cs_response_packer;

    logic        clk64         = 1'b0;
    logic        reset         = 1'b1;
    logic        resp_valid    = 1'b0;
    logic        resp_ready;
    logic [7:0]  resp_opcode   = 8'h00;
    logic [5:0]  resp_rid      = 6'h00;
    logic [31:0] resp_data     = 32'h0;
    logic        rx_WR_enabled = 1'b0;
    logic        rx_WR;
    logic [15:0] rx_databus;
    logic        rx_WR_done;
    logic [15:0] pkts_sent;

    int vectors     = 0;
    int miscompares = 0;

    // Bus monitor state, written only by the monitor process.
    int          cyc      = 0;
    logic [15:0] cap [4096];
    int          cap_n    = 0;
    int          run      = 0;
    int          last_run = 0;
    int          rise_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          acc_cnt  = 0;

    // Expected subpacket contents per packet slot.
    logic [7:0]  exp_op   [31];
    logic [5:0]  exp_rid  [31];
    logic [31:0] exp_data [31];

    cs_response_packer dut (
        .clk64         (clk64),
        .reset         (reset),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_opcode   (resp_opcode),
        .resp_rid      (resp_rid),
        .resp_data     (resp_data),
        .rx_WR_enabled (rx_WR_enabled),
        .rx_WR         (rx_WR),
        .rx_databus    (rx_databus),
        .rx_WR_done    (rx_WR_done),
        .pkts_sent     (pkts_sent)
    );

    always #5 clk64 = ~clk64;

    always @(posedge clk64) cyc = cyc + 1;

    always @(negedge clk64) begin
        if (rx_WR) begin
            if (run == 0) rise_cyc = cyc;
            if (cap_n < 4096) cap[cap_n] = rx_databus;
            cap_n = cap_n + 1;
            run   = run + 1;
        end else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
        if (rx_WR_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (resp_valid && resp_ready && !reset) acc_cnt = acc_cnt + 1;
    end

    function automatic logic [15:0] expected_word(input int idx, input int nsub);
        int s;
        int f;
        if (idx == 0) return 16'(nsub * 8);
        if (idx == 1) return 16'h001F;
        if (idx < 4) return 16'hFFFF;
        s = (idx - 4) / 4;
        f = (idx - 4) % 4;
        if (s >= nsub) return 16'h0000;
        case (f)
            0:       return {exp_op[s], 8'h06};
            1:       return {10'b0, exp_rid[s]};
            2:       return exp_data[s][31:16];
            default: return exp_data[s][15:0];
        endcase
    endfunction

    // Offers one record; must be called just after a rising edge. Returns the
    // cycle number of the accepting edge, or -1 if never accepted.
    task automatic send_record(input logic [7:0] op, input logic [5:0] rid,
                               input logic [31:0] data, output int acc_at);
        logic ok;
        resp_opcode = op;
        resp_rid    = rid;
        resp_data   = data;
        resp_valid  = 1'b1;
        acc_at      = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk64);
            ok = resp_ready;
            @(posedge clk64);
            #1;
            if (ok) begin
                acc_at = cyc;
                break;
            end
        end
        resp_valid = 1'b0;
        if (acc_at < 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL record_accept: rid %0d never accepted, required acceptance", rid);
        end
    endtask

    task automatic wait_packet(input int max_cyc, input int start_done);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk64);
            if (done_cnt != start_done) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL packet_wait: no rx_WR_done within %0d cycles, required one", max_cyc);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        resp_valid    = 1'b1;
        rx_WR_enabled = 1'b1;
        repeat (3) @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (resp_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 0", resp_ready);
        end
        vectors++;
        if (rx_WR !== 1'b0 || rx_WR_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: rx_WR %b done %b expected 0 0", rx_WR, rx_WR_done);
        end
        vectors++;
        if (rx_databus !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 0000", rx_databus);
        end
        vectors++;
        if (pkts_sent !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_pkts: got %h expected 0000", pkts_sent);
        end
        @(posedge clk64);
        #1;
        reset      = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk64);
        vectors++;
        if (resp_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_ready: got %b expected 1", resp_ready);
        end
    endtask

    task automatic test_single_timeout();
        int acc;
        int base;
        int d0;
        @(posedge clk64);
        #1;
        base        = cap_n;
        d0          = done_cnt;
        exp_op[0]   = 8'h81;
        exp_rid[0]  = 6'd5;
        exp_data[0] = 32'hDEADBEEF;
        send_record(8'h81, 6'd5, 32'hDEADBEEF, acc);
        wait_packet(1300, d0);
        vectors++;
        if (rise_cyc - acc !== 1025) begin
            miscompares++;
            $display("[TB] FAIL single_latency: got %0d expected 1025", rise_cyc - acc);
        end
        vectors++;
        if (cap_n - base !== 128 || last_run !== 128) begin
            miscompares++;
            $display("[TB] FAIL single_length: words %0d run %0d expected 128 128", cap_n - base, last_run);
        end
        vectors++;
        if (cap[base] !== 16'h0008 || cap[base+4] !== 16'h8106 || cap[base+6] !== 16'hDEAD) begin
            miscompares++;
            $display("[TB] FAIL single_fields: got %h %h %h expected 0008 8106 dead",
                     cap[base], cap[base+4], cap[base+6]);
        end
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 1)) begin
                miscompares++;
                $display("[TB] FAIL single_word[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 1));
            end
        end
        vectors++;
        if (done_cyc - rise_cyc !== 128) begin
            miscompares++;
            $display("[TB] FAIL single_done_time: got %0d expected 128", done_cyc - rise_cyc);
        end
        repeat (3) @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (pkts_sent !== 16'd1 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_count: pkts %0d pulses %0d expected 1 1", pkts_sent, done_cnt - d0);
        end
    endtask

    task automatic test_full_packet();
        int acc;
        int base;
        int d0;
        @(posedge clk64);
        #1;
        base = cap_n;
        d0   = done_cnt;
        for (int i = 0; i < 31; i++) begin
            exp_op[i]   = 8'(8'hA0 + i);
            exp_rid[i]  = 6'(i);
            exp_data[i] = 32'h1234_0000 + 32'(i) * 32'h0001_0001;
        end
        for (int i = 0; i < 31; i++) send_record(exp_op[i], exp_rid[i], exp_data[i], acc);
        @(negedge clk64);
        vectors++;
        if (resp_ready !== 1'b0 || rx_WR !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_ready: ready %b wr %b expected 0 0", resp_ready, rx_WR);
        end
        wait_packet(300, d0);
        vectors++;
        if (rise_cyc - acc !== 1) begin
            miscompares++;
            $display("[TB] FAIL full_latency: got %0d expected 1", rise_cyc - acc);
        end
        vectors++;
        if (cap[base] !== 16'h00F8 || cap[base+124] !== 16'hBE06 || cap[base+125] !== 16'h001E) begin
            miscompares++;
            $display("[TB] FAIL full_fields: got %h %h %h expected 00f8 be06 001e",
                     cap[base], cap[base+124], cap[base+125]);
        end
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 31)) begin
                miscompares++;
                $display("[TB] FAIL full_word[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 31));
            end
        end
        vectors++;
        if (last_run !== 128 || done_cyc - rise_cyc !== 128) begin
            miscompares++;
            $display("[TB] FAIL full_run: run %0d done_at %0d expected 128 128", last_run, done_cyc - rise_cyc);
        end
        @(negedge clk64);
        vectors++;
        if (resp_ready !== 1'b1 || pkts_sent !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL full_after: ready %b pkts %0d expected 1 2", resp_ready, pkts_sent);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int d0;
        int a0;
        @(posedge clk64);
        #1;
        rx_WR_enabled = 1'b0;
        base = cap_n;
        d0   = done_cnt;
        a0   = acc_cnt;
        fork
            begin
                int a;
                for (int i = 0; i < 40; i++) send_record(8'(8'h20 + i), 6'(i), 32'hA5A5_0000 + 32'(i), a);
            end
        join_none
        repeat (200) @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (acc_cnt - a0 !== 31 || resp_ready !== 1'b0 || cap_n !== base) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: accepted %0d ready %b words %0d expected 31 0 0",
                     acc_cnt - a0, resp_ready, cap_n - base);
        end
        for (int i = 0; i < 31; i++) begin
            exp_op[i]   = 8'(8'h20 + i);
            exp_rid[i]  = 6'(i);
            exp_data[i] = 32'hA5A5_0000 + 32'(i);
        end
        @(posedge clk64);
        #1;
        rx_WR_enabled = 1'b1;
        wait_packet(300, d0);
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 31)) begin
                miscompares++;
                $display("[TB] FAIL bp_word1[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 31));
            end
        end
        base = cap_n;
        d0   = done_cnt;
        for (int i = 0; i < 9; i++) begin
            exp_op[i]   = 8'(8'h20 + 31 + i);
            exp_rid[i]  = 6'(31 + i);
            exp_data[i] = 32'hA5A5_0000 + 32'(31 + i);
        end
        wait_packet(1500, d0);
        vectors++;
        if (cap[base] !== 16'h0048 || cap[base+5] !== 16'h001F) begin
            miscompares++;
            $display("[TB] FAIL bp_second: got %h %h expected 0048 001f", cap[base], cap[base+5]);
        end
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 9)) begin
                miscompares++;
                $display("[TB] FAIL bp_word2[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 9));
            end
        end
        wait fork;
        vectors++;
        if (acc_cnt - a0 !== 40) begin
            miscompares++;
            $display("[TB] FAIL bp_total: accepted %0d expected 40", acc_cnt - a0);
        end
    endtask

    task automatic test_enable_drop();
        int acc;
        int base;
        int d0;
        @(posedge clk64);
        #1;
        base = cap_n;
        d0   = done_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_op[i]   = 8'(8'h60 + i);
            exp_rid[i]  = 6'(40 + i);
            exp_data[i] = 32'hC0DE_0000 + 32'(i);
            send_record(exp_op[i], exp_rid[i], exp_data[i], acc);
        end
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk64);
            if (cap_n - base >= 50) break;
        end
        rx_WR_enabled = 1'b0;
        wait_packet(300, d0);
        vectors++;
        if (cap_n - base !== 128 || last_run !== 128 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL drop_run: words %0d run %0d pulses %0d expected 128 128 1",
                     cap_n - base, last_run, done_cnt - d0);
        end
        vectors++;
        if (cap[base] !== 16'h0018) begin
            miscompares++;
            $display("[TB] FAIL drop_len: got %h expected 0018", cap[base]);
        end
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 3)) begin
                miscompares++;
                $display("[TB] FAIL drop_word[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 3));
            end
        end
        rx_WR_enabled = 1'b1;
    endtask

    task automatic test_reset_mid_emit();
        int acc;
        int base;
        int d0;
        @(posedge clk64);
        #1;
        base = cap_n;
        d0   = done_cnt;
        send_record(8'h11, 6'd1, 32'h1111_1111, acc);
        send_record(8'h22, 6'd2, 32'h2222_2222, acc);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk64);
            if (cap_n - base >= 60) break;
        end
        @(posedge clk64);
        #1;
        reset = 1'b1;
        @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (rx_WR !== 1'b0 || pkts_sent !== 16'h0000 || resp_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_emit: wr %b pkts %h ready %b expected 0 0000 0", rx_WR, pkts_sent, resp_ready);
        end
        @(posedge clk64);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk64);
        vectors++;
        if (done_cnt !== d0) begin
            miscompares++;
            $display("[TB] FAIL rst_done: pulses %0d expected 0", done_cnt - d0);
        end
        @(posedge clk64);
        #1;
        base        = cap_n;
        exp_op[0]   = 8'h33;
        exp_rid[0]  = 6'd3;
        exp_data[0] = 32'h3333_4444;
        send_record(8'h33, 6'd3, 32'h3333_4444, acc);
        wait_packet(1300, d0);
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (cap[base+i] !== expected_word(i, 1)) begin
                miscompares++;
                $display("[TB] FAIL rst_word[%0d]: got %h expected %h", i, cap[base+i], expected_word(i, 1));
            end
        end
        repeat (3) @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (pkts_sent !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL rst_pkts: got %0d expected 1", pkts_sent);
        end
    endtask

    task automatic test_wrap();
        int acc;
        int d0;
        @(negedge clk64);
        force dut.pkts_sent = 16'hFFFF;
        @(posedge clk64);
        #1;
        release dut.pkts_sent;
        @(negedge clk64);
        vectors++;
        if (pkts_sent !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL wrap_preset: got %h expected ffff", pkts_sent);
        end
        @(posedge clk64);
        #1;
        d0 = done_cnt;
        send_record(8'h44, 6'd4, 32'h5555_6666, acc);
        wait_packet(1300, d0);
        repeat (3) @(posedge clk64);
        @(negedge clk64);
        vectors++;
        if (pkts_sent !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %h expected 0000", pkts_sent);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_timeout();
        test_full_packet();
        test_backpressure();
        test_enable_drop();
        test_reset_mid_emit();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
